multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle successor to the single-cycle MIPS controller: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles so one ALU and one unified memory port serve the whole datapath. It adds a memory ready/wait handshake with bounded timeout, a sticky fault state for illegal opcodes and memory timeouts, and a retired-instruction counter. It sits between the instruction register/zero flag and the multi-cycle datapath's muxes and write enables.

## Interface
- `MEM_WAIT_MAX`, 15: maximum cycles a memory state waits for `mem_ready` before faulting (1..255).
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `func` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_read`, `mem_write` out 1: memory strobes.
- `i_or_d` out 1: 0 = PC addresses memory, 1 = ALUOut.
- `ir_write` out 1: load IR.
- `pc_en` out 1: PC load enable, branch condition already folded in.
- `pc_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- `alu_operation` out 3: ALU function.
- `reg_dst`, `mem_to_reg`, `reg_write` out 1: register-file controls.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `instr_count` out CNT_W: retired instructions.
- `fault` out 1: sticky error flag.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, FAULT.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, alu add. When `mem_ready`=1: `ir_write`=1, `pc_en`=1, go to DECODE. Otherwise stay.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, alu add (branch target into ALUOut). Next state by opcode:
  - LW 100011 / SW 101011 → MEM_ADDR
  - R-type 000000 → EXEC_R
  - ADDI 001000 / ANDI 001100 → EXEC_I
  - BEQ 000100 / BNE 000101 → BRANCH
  - J 000010 → JUMP
  - anything else → FAULT
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, add. Next is MEM_RD for LW or MEM_WR for SW.
- MEM_RD: `mem_read`=1, `i_or_d`=1. On `mem_ready` go to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `retire`=1.
- MEM_WR: `mem_write`=1, `i_or_d`=1. On `mem_ready`: `retire`=1, go to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, ALU op from `func`.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, ALU op is add for ADDI or and for ANDI.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0, `reg_dst`=1 for R-type and 0 for immediates; `retire`=1.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, subtract, `pc_source`=01. `pc_en` = `zero` for BEQ, `~zero` for BNE. `retire`=1.
- JUMP: `pc_source`=10, `pc_en`=1, `retire`=1.
- Unsupported R-type `func` (not add/sub/and/or/slt) → FAULT from EXEC_R; no register write.
- Memory wait:
  - An 8-bit wait counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle `mem_ready`=0.
  - When the count reaches `MEM_WAIT_MAX` with `mem_ready` still 0, go to FAULT.
  - `mem_ready`=1 on the final allowed cycle counts as success.
- FAULT: all strobes 0, `fault`=1, held until reset.
- `instr_count` increments by 1 on every `retire` and wraps modulo 2^CNT_W.
- Every state not listed above returns to FETCH after one cycle.

## Timing
- During reset (`rst_n`=0 at an edge): state becomes FETCH, wait counter 0, `instr_count` 0, `fault` 0.
- While `rst_n` is low, all strobes (`mem_read`, `mem_write`, `ir_write`, `pc_en`, `reg_write`, `retire`) are forced to 0.
- Reset mid-instruction aborts it; no partial write-back.
- Cycles per instruction with `mem_ready` always 1: R/ADDI/ANDI 4, LW 5, SW 4, BEQ/BNE/J 3. Each memory wait cycle adds 1.
- All outputs are combinational from state (plus `zero`, `mem_ready`, `opcode`, `func`); there is no output register.
- `instr_count` updates the edge after `retire`.

## Structure
- Shared package `mips_defs`: opcode and func constants, `alu_op` encodings (MTYPE 00, BTYPE 01, RTYPE 10), and the state enum.
- One sub-module: the existing `alu_controller`, driven by `alu_op` and the mapped func (ADD for ADDI, AND for ANDI).

## Test plan
- Reset, then ADD (opcode 0, func 100000) with `mem_ready`=1 → `reg_write` and `reg_dst` high in cycle 4; `instr_count`=1.
- LW with `mem_ready` low for 3 cycles in MEM_RD → `reg_write` in cycle 8; `mem_to_reg`=1.
- BEQ with `zero`=1 gives `pc_en`=1 and `pc_source`=01 in cycle 3. BNE with `zero`=1 gives `pc_en`=0.
- Opcode 111111 → FAULT after DECODE; `fault`=1 stays; no strobes until `rst_n`=0.
- `mem_ready` held 0 in FETCH with `MEM_WAIT_MAX`=15 → `fault`=1 after 15 cycles. `mem_ready`=1 on the 15th cycle instead → DECODE.
- Assert `rst_n`=0 in MEM_WR → `mem_write` 0 that cycle, state FETCH, `instr_count`=0. Separately, `CNT_W`=4 wraps to 0 after 16 retires.

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared opcode, func, ALU and state definitions for the multi-cycle controller
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_FN_AND = 3'b000;
    localparam logic [2:0] ALU_FN_OR  = 3'b001;
    localparam logic [2:0] ALU_FN_ADD = 3'b010;
    localparam logic [2:0] ALU_FN_SUB = 3'b110;
    localparam logic [2:0] ALU_FN_SLT = 3'b111;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    typedef enum logic [1:0] {
        ALU_OP_MTYPE = 2'b00,
        ALU_OP_BTYPE = 2'b01,
        ALU_OP_RTYPE = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_FAULT
    } state_t;

    function automatic logic func_supported(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:     return S_MEM_ADDR;
            OP_RTYPE:         return S_EXEC_R;
            OP_ADDI, OP_ANDI: return S_EXEC_I;
            OP_BEQ, OP_BNE:   return S_BRANCH;
            OP_J:             return S_JUMP;
            default:          return S_FAULT;
        endcase
    endfunction

endpackage

// File: rtl/alu_controller.sv
// rtl/alu_controller.sv - maps alu_op class and func field to a 3-bit ALU function
module alu_controller
    import mips_defs::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] func,
    output logic [2:0] alu_operation
);

    always_comb begin
        alu_operation = ALU_FN_ADD;
        case (alu_op)
            ALU_OP_MTYPE: alu_operation = ALU_FN_ADD;
            ALU_OP_BTYPE: alu_operation = ALU_FN_SUB;
            ALU_OP_RTYPE: begin
                case (func)
                    FN_ADD:  alu_operation = ALU_FN_ADD;
                    FN_SUB:  alu_operation = ALU_FN_SUB;
                    FN_AND:  alu_operation = ALU_FN_AND;
                    FN_OR:   alu_operation = ALU_FN_OR;
                    FN_SLT:  alu_operation = ALU_FN_SLT;
                    default: alu_operation = ALU_FN_ADD;
                endcase
            end
            default: alu_operation = ALU_FN_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS control FSM with memory wait timeout, fault and retire count
module multicycle_controller
    import mips_defs::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_operation,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             fault
);

    // A wait is fatal when the counter would reach MEM_WAIT_MAX this cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       wait_expired;
    logic       mem_wait;
    alu_op_t    alu_op;
    logic [5:0] alu_func;

    assign wait_expired = !mem_ready && (wait_cnt == WAIT_LAST);
    assign fault        = (state == S_FAULT);

    alu_controller u_alu_controller (
        .alu_op        (alu_op),
        .func          (alu_func),
        .alu_operation (alu_operation)
    );

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_OP_MTYPE;
        alu_func   = FN_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        mem_wait   = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_en      = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b  = SRC_B_IMM_SH;
                state_next = decode_next(opcode);
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_RTYPE;
                alu_func   = func;
                state_next = func_supported(func) ? S_ALU_WB : S_FAULT;
            end
            S_EXEC_I: begin
                // Immediates reuse the R-type path with a synthesised func field.
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_OP_RTYPE;
                alu_func   = (opcode == OP_ANDI) ? FN_AND : FN_ADD;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_BTYPE;
                pc_source  = PC_SRC_ALUOUT;
                pc_en      = (opcode == OP_BNE) ? !zero : zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = PC_SRC_JUMP;
                pc_en      = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Strobes are suppressed for the whole reset cycle so an aborted access never commits.
        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            wait_cnt    <= 8'd0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= 8'd0;
            end else if (mem_wait) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_BAD   = 6'b000001;

    typedef enum {P_RST, P_F, P_D, P_MA, P_MRD, P_MWB, P_MWR, P_EXR, P_EXI, P_AWB, P_BR, P_J, P_FLT} phase_t;

    typedef struct {
        int          idx;
        string       name;
        logic [5:0]  strb;
        logic        chk_mem, chk_pc, chk_alu, chk_aop, chk_rf, chk_flt;
        logic        i_or_d;
        logic [1:0]  pc_source;
        logic        src_a;
        logic [1:0]  src_b;
        logic [2:0]  aop;
        logic        reg_dst, mem_to_reg, fault;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] func = 6'd0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;

    logic mem_read, mem_write, i_or_d, ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write, retire, fault;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_operation;
    logic [31:0] instr_count;
    logic mem_read4, mem_write4, i_or_d4, ir_write4, pc_en4, alu_src_a4, reg_dst4, mem_to_reg4, reg_write4, retire4, fault4;
    logic [1:0] pc_source4, alu_src_b4;
    logic [2:0] alu_operation4;
    logic [3:0] instr_count4;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] model_cnt = 32'd0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_operation(alu_operation),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
        .instr_count(instr_count), .fault(fault)
    );

    multicycle_controller #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read4), .mem_write(mem_write4), .i_or_d(i_or_d4), .ir_write(ir_write4), .pc_en(pc_en4),
        .pc_source(pc_source4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_operation(alu_operation4),
        .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .reg_write(reg_write4), .retire(retire4),
        .instr_count(instr_count4), .fault(fault4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected outputs per phase, written from the state table of the controller.
    function automatic exp_t model(input phase_t p, input logic [5:0] op, input logic [5:0] fn,
                                   input logic rdy, input logic z);
        exp_t e;
        e.idx = 0; e.name = ""; e.strb = 6'b0; e.cnt = 32'd0;
        e.chk_mem = 0; e.chk_pc = 0; e.chk_alu = 0; e.chk_aop = 0; e.chk_rf = 0; e.chk_flt = 1;
        e.i_or_d = 0; e.pc_source = 2'b00; e.src_a = 0; e.src_b = 2'b00; e.aop = 3'b010;
        e.reg_dst = 0; e.mem_to_reg = 0; e.fault = 0;
        // strb = {mem_read, mem_write, ir_write, pc_en, reg_write, retire}
        case (p)
            P_RST: begin e.name = "rst"; e.chk_flt = 0; end
            P_F: begin
                e.name = "fetch"; e.strb = {1'b1, 1'b0, rdy, rdy, 2'b00};
                e.chk_mem = 1; e.chk_pc = 1; e.chk_alu = 1; e.chk_aop = 1; e.src_b = 2'b01;
            end
            P_D: begin e.name = "decode"; e.chk_alu = 1; e.chk_aop = 1; e.src_b = 2'b11; end
            P_MA: begin e.name = "memaddr"; e.chk_alu = 1; e.chk_aop = 1; e.src_a = 1; e.src_b = 2'b10; end
            P_MRD: begin e.name = "memrd"; e.strb = 6'b100000; e.chk_mem = 1; e.i_or_d = 1; end
            P_MWB: begin e.name = "memwb"; e.strb = 6'b000011; e.chk_rf = 1; e.mem_to_reg = 1; end
            P_MWR: begin e.name = "memwr"; e.strb = {5'b01000, rdy}; e.chk_mem = 1; e.i_or_d = 1; end
            P_EXR: begin
                e.name = "execr"; e.chk_alu = 1; e.src_a = 1;
                e.chk_aop = 1;
                case (fn)
                    F_ADD: e.aop = 3'b010;
                    F_SUB: e.aop = 3'b110;
                    F_AND: e.aop = 3'b000;
                    F_OR:  e.aop = 3'b001;
                    F_SLT: e.aop = 3'b111;
                    default: e.chk_aop = 0;
                endcase
            end
            P_EXI: begin
                e.name = "execi"; e.chk_alu = 1; e.chk_aop = 1; e.src_a = 1; e.src_b = 2'b10;
                e.aop = (op == OP_ANDI) ? 3'b000 : 3'b010;
            end
            P_AWB: begin e.name = "aluwb"; e.strb = 6'b000011; e.chk_rf = 1; e.reg_dst = (op == OP_R); end
            P_BR: begin
                e.name = "branch"; e.chk_alu = 1; e.chk_aop = 1; e.src_a = 1; e.aop = 3'b110;
                e.chk_pc = 1; e.pc_source = 2'b01;
                e.strb = {3'b000, (op == OP_BEQ) ? z : !z, 2'b01};
            end
            P_J: begin e.name = "jump"; e.strb = 6'b000101; e.chk_pc = 1; e.pc_source = 2'b10; end
            P_FLT: begin e.name = "fault"; e.fault = 1; end
            default: e.name = "?";
        endcase
        return e;
    endfunction

    task automatic v(input phase_t p, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic z);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = (p != P_RST);
        opcode = op; func = fn; mem_ready = rdy; zero = z;
        e = model(p, op, fn, rdy, z);
        e.idx = cyc; e.cnt = model_cnt;
        sb.push_back(e);
        cyc++;
        if (p == P_RST) model_cnt = 32'd0;
        else if (e.strb[0]) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic run_r(input logic [5:0] fn);
        v(P_F, OP_R, fn, 1, 0); v(P_D, OP_R, fn, 1, 0); v(P_EXR, OP_R, fn, 1, 0); v(P_AWB, OP_R, fn, 1, 0);
    endtask

    task automatic run_i(input logic [5:0] op);
        v(P_F, op, 6'd0, 1, 0); v(P_D, op, 6'd0, 1, 0); v(P_EXI, op, 6'd0, 1, 0); v(P_AWB, op, 6'd0, 1, 0);
    endtask

    task automatic run_br(input logic [5:0] op, input logic z);
        v(P_F, op, 6'd0, 1, z); v(P_D, op, 6'd0, 1, z); v(P_BR, op, 6'd0, 1, z);
    endtask

    task automatic run_j();
        v(P_F, OP_J, 6'd0, 1, 0); v(P_D, OP_J, 6'd0, 1, 0); v(P_J, OP_J, 6'd0, 1, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        string t;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = $sformatf("c%0d %s", e.idx, e.name);
            chk({t, " strobes"}, 32'({mem_read, mem_write, ir_write, pc_en, reg_write, retire}), 32'(e.strb));
            chk({t, " strobes4"}, 32'({mem_read4, mem_write4, ir_write4, pc_en4, reg_write4, retire4}), 32'(e.strb));
            if (e.chk_mem) chk({t, " i_or_d"}, 32'({i_or_d, i_or_d4}), 32'({2{e.i_or_d}}));
            if (e.chk_pc) chk({t, " pc_source"}, 32'({pc_source, pc_source4}), 32'({2{e.pc_source}}));
            if (e.chk_alu) chk({t, " alu_src"}, 32'({alu_src_a, alu_src_b, alu_src_a4, alu_src_b4}),
                               32'({2{e.src_a, e.src_b}}));
            if (e.chk_aop) chk({t, " alu_operation"}, 32'({alu_operation, alu_operation4}), 32'({2{e.aop}}));
            if (e.chk_rf) chk({t, " reg_dst/mem_to_reg"}, 32'({reg_dst, mem_to_reg, reg_dst4, mem_to_reg4}),
                              32'({2{e.reg_dst, e.mem_to_reg}}));
            if (e.chk_flt) chk({t, " fault"}, 32'({fault, fault4}), 32'({2{e.fault}}));
            chk({t, " instr_count"}, instr_count, e.cnt);
            chk({t, " instr_count4"}, 32'(instr_count4), 32'(e.cnt[3:0]));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        v(P_RST, 6'd0, 6'd0, 0, 0);
        v(P_RST, 6'd0, 6'd0, 0, 0);

        run_r(F_ADD);

        v(P_F, OP_LW, 6'd0, 1, 0); v(P_D, OP_LW, 6'd0, 1, 0); v(P_MA, OP_LW, 6'd0, 1, 0);
        repeat (3) v(P_MRD, OP_LW, 6'd0, 0, 0);
        v(P_MRD, OP_LW, 6'd0, 1, 0); v(P_MWB, OP_LW, 6'd0, 1, 0);

        v(P_F, OP_SW, 6'd0, 1, 0); v(P_D, OP_SW, 6'd0, 1, 0); v(P_MA, OP_SW, 6'd0, 1, 0);
        v(P_MWR, OP_SW, 6'd0, 1, 0);

        run_br(OP_BEQ, 1); run_br(OP_BNE, 1); run_br(OP_BEQ, 0); run_br(OP_BNE, 0);
        run_j();
        run_r(F_SUB); run_r(F_AND); run_r(F_OR); run_r(F_SLT);
        run_i(OP_ADDI); run_i(OP_ANDI);

        // Ready arrives on the last allowed fetch cycle.
        repeat (14) v(P_F, OP_R, F_ADD, 0, 0);
        v(P_F, OP_R, F_ADD, 1, 0); v(P_D, OP_R, F_ADD, 1, 0); v(P_EXR, OP_R, F_ADD, 1, 0); v(P_AWB, OP_R, F_ADD, 1, 0);

        // Reset while a store is waiting: no write, no retire, counter cleared.
        v(P_F, OP_SW, 6'd0, 1, 0); v(P_D, OP_SW, 6'd0, 1, 0); v(P_MA, OP_SW, 6'd0, 1, 0);
        v(P_MWR, OP_SW, 6'd0, 0, 0);
        v(P_RST, OP_SW, 6'd0, 1, 0);

        repeat (17) run_j();

        v(P_F, OP_R, F_BAD, 1, 0); v(P_D, OP_R, F_BAD, 1, 0); v(P_EXR, OP_R, F_BAD, 1, 0);
        repeat (2) v(P_FLT, OP_R, F_BAD, 1, 0);
        v(P_RST, 6'd0, 6'd0, 1, 0);

        v(P_F, OP_BAD, 6'd0, 1, 0); v(P_D, OP_BAD, 6'd0, 1, 0);
        repeat (3) v(P_FLT, OP_BAD, 6'd0, 1, 1);
        v(P_RST, 6'd0, 6'd0, 1, 0);

        repeat (15) v(P_F, OP_R, F_ADD, 0, 0);
        repeat (2) v(P_FLT, OP_R, F_ADD, 1, 0);
        v(P_RST, 6'd0, 6'd0, 1, 0);

        v(P_F, OP_LW, 6'd0, 1, 0); v(P_D, OP_LW, 6'd0, 1, 0); v(P_MA, OP_LW, 6'd0, 1, 0);
        repeat (15) v(P_MRD, OP_LW, 6'd0, 0, 0);
        v(P_FLT, OP_LW, 6'd0, 1, 0);
        v(P_RST, 6'd0, 6'd0, 1, 0);

        run_r(F_ADD);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) chk("scoreboard drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
